i2c_slave_target: RTL

I2C_SLAVE_TARGET -- requirements
Module: i2c_slave_target

---
 rtl/i2c_slave_target_if.sv | 12 +
 rtl/i2c_slave_target.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_target_if.sv
// Byte-level handshake between the I2C target and the local logic that
// supplies read data and consumes written data.
interface i2c_slave_target_if;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rd_done;
  logic       busy;

  modport slave  (input  tx_data, output rx_data, rx_valid, rd_done, busy);
  modport master (output tx_data, input  rx_data, rx_valid, rd_done, busy);
endinterface

// File: rtl/i2c_slave_target.sv
// I2C target with one fixed 7-bit address. It ACKs written bytes and
// returns tx_data on reads. SCL and SDA are oversampled on clk, and SDA
// is only ever pulled low or released (open drain).
module i2c_slave_target #(
  parameter logic [6:0] SLAVE_ADDR = 7'h2A
) (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  inout  wire  sda,
  i2c_slave_target_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_DATA,
    S_WR_ACK,
    S_RD_DATA,
    S_RD_ACK,
    S_WAIT_STOP
  } state_t;

  state_t     r_state;
  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       r_scl_prev;
  logic       r_sda_prev;
  logic [3:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       r_rw;
  logic       r_phase;    // ACK states: second half reached / master ACK seen
  logic       r_sda_oe;
  logic       r_rx_pend;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_rd_done;

  logic w_scl;
  logic w_sda;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  assign w_scl      = r_scl_sync[1];
  assign w_sda      = r_sda_sync[1];
  assign w_scl_rise = w_scl & ~r_scl_prev;
  assign w_scl_fall = ~w_scl & r_scl_prev;
  assign w_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
  assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

  assign sda          = r_sda_oe ? 1'b0 : 1'bz;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign bus.rd_done  = r_rd_done;
  assign bus.busy     = (r_state != S_IDLE);

  // Two-flop synchronisers plus one delayed copy for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl};
      r_sda_sync <= {r_sda_sync[0], sda};
      r_scl_prev <= r_scl_sync[1];
      r_sda_prev <= r_sda_sync[1];
    end
  end

  // Protocol FSM. START and STOP take priority over every state transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_rw       <= 1'b0;
      r_phase    <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_rx_pend  <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_rd_done  <= 1'b0;
    end else begin
      r_rx_valid <= r_rx_pend;
      r_rx_pend  <= 1'b0;
      r_rd_done  <= 1'b0;
      if (w_start) begin
        r_state   <= S_ADDR;
        r_bit_cnt <= '0;
        r_phase   <= 1'b0;
        r_sda_oe  <= 1'b0;
      end else if (w_stop) begin
        r_state   <= S_IDLE;
        r_bit_cnt <= '0;
        r_phase   <= 1'b0;
        r_sda_oe  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
          end
          S_ADDR: begin
            if (w_scl_rise) begin
              r_shift <= {r_shift[6:0], w_sda};
              if (r_bit_cnt == 4'd7) begin
                r_bit_cnt <= '0;
                r_rw      <= w_sda;
                r_phase   <= 1'b0;
                // r_shift[6:0] already holds the seven address bits.
                if (r_shift[6:0] == SLAVE_ADDR) r_state <= S_ADDR_ACK;
                else                             r_state <= S_WAIT_STOP;
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              if (!r_phase) begin
                r_phase  <= 1'b1;
                r_sda_oe <= 1'b1;
              end else begin
                r_phase <= 1'b0;
                if (r_rw) begin
                  r_shift   <= bus.tx_data;
                  r_sda_oe  <= ~bus.tx_data[7];
                  r_bit_cnt <= 4'd1;
                  r_state   <= S_RD_DATA;
                end else begin
                  r_sda_oe  <= 1'b0;
                  r_bit_cnt <= '0;
                  r_state   <= S_WR_DATA;
                end
              end
            end
          end
          S_WR_DATA: begin
            if (w_scl_rise) begin
              r_shift <= {r_shift[6:0], w_sda};
              if (r_bit_cnt == 4'd7) begin
                r_rx_data <= {r_shift[6:0], w_sda};
                r_rx_pend <= 1'b1;
                r_bit_cnt <= '0;
                r_phase   <= 1'b0;
                r_state   <= S_WR_ACK;
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          S_WR_ACK: begin
            if (w_scl_fall) begin
              if (!r_phase) begin
                r_phase  <= 1'b1;
                r_sda_oe <= 1'b1;
              end else begin
                r_phase  <= 1'b0;
                r_sda_oe <= 1'b0;
                r_state  <= S_WR_DATA;
              end
            end
          end
          S_RD_DATA: begin
            // r_bit_cnt counts bits already presented on sda.
            if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_sda_oe  <= 1'b0;
                r_bit_cnt <= '0;
                r_phase   <= 1'b0;
                r_state   <= S_RD_ACK;
              end else begin
                r_shift   <= {r_shift[6:0], 1'b0};
                r_sda_oe  <= ~r_shift[6];
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          S_RD_ACK: begin
            if (!r_phase) begin
              if (w_scl_rise) begin
                r_rd_done <= 1'b1;
                if (w_sda) r_state <= S_WAIT_STOP;
                else       r_phase <= 1'b1;
              end
            end else if (w_scl_fall) begin
              // After an ACK, the next byte is loaded at the fall that ends the ACK clock.
              r_phase   <= 1'b0;
              r_shift   <= bus.tx_data;
              r_sda_oe  <= ~bus.tx_data[7];
              r_bit_cnt <= 4'd1;
              r_state   <= S_RD_DATA;
            end
          end
          S_WAIT_STOP: begin
            r_sda_oe <= 1'b0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
